// File: rtl/rggen_apb_adapter_pkg.sv
// Shared definitions for the register-bus adapters: access-bit positions,
// status codes and the adapter FSM state encoding.
package rggen_apb_adapter_pkg;

   localparam int RGGEN_ACCESS_WRITE_BIT      = 0;
   localparam int RGGEN_ACCESS_PRIVILEGED_BIT = 1;

   localparam logic [1:0] RGGEN_STATUS_OKAY  = 2'b00;
   localparam logic [1:0] RGGEN_STATUS_ERROR = 2'b10;

   typedef enum logic [1:0] {
      STATE_IDLE     = 2'b00,
      STATE_ACCESS   = 2'b01,
      STATE_RESPONSE = 2'b10
   } rggen_adapter_state_e;

endpackage

// File: rtl/rggen_apb_adapter_common.sv
// Bus-agnostic adapter core: request capture, optional pre-decode, the
// register-bus handshake FSM and OR-collection of register responses.
module rggen_adapter_common
   import rggen_apb_adapter_pkg::*;
#(
   parameter int              ADDRESS_WIDTH       = 8,
   parameter int              LOCAL_ADDRESS_WIDTH = 8,
   parameter int              BUS_WIDTH           = 32,
   parameter int              REGISTERS           = 1,
   parameter bit              PRE_DECODE          = 1'b0,
   parameter bit [63:0]       BASE_ADDRESS        = '0,
   parameter bit [63:0]       BYTE_SIZE           = 64'd256,
   parameter bit              ERROR_STATUS        = 1'b0,
   parameter bit [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_request_valid,
   input  logic [1:0]                     i_request_access,
   input  logic [ADDRESS_WIDTH-1:0]       i_request_address,
   input  logic [BUS_WIDTH-1:0]           i_request_write_data,
   input  logic [BUS_WIDTH-1:0]           i_request_strobe,
   output logic                           o_response_valid,
   output logic                           o_response_error,
   output logic [BUS_WIDTH-1:0]           o_response_data,
   output logic                           o_register_valid,
   output logic [1:0]                     o_register_access,
   output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
   output logic [BUS_WIDTH-1:0]           o_register_write_data,
   output logic [BUS_WIDTH-1:0]           o_register_strobe,
   input  logic [REGISTERS-1:0]           i_register_active,
   input  logic [REGISTERS-1:0]           i_register_ready,
   input  logic [2*REGISTERS-1:0]         i_register_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

   localparam int ADDRESS_LSB = $clog2(BUS_WIDTH / 8);
   localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ADDRESS_MASK =
      ~LOCAL_ADDRESS_WIDTH'((1 << ADDRESS_LSB) - 1);

   rggen_adapter_state_e       state;
   logic [64:0]                offset;
   logic                       reject;
   logic                       any_ready;
   logic                       any_error;
   logic [BUS_WIDTH-1:0]       collected_data;

   // A borrow out of the subtraction means the address lies below the base.
   assign offset = {1'b0, 64'(i_request_address)} - {1'b0, BASE_ADDRESS};
   assign reject = PRE_DECODE && (offset[64] || (offset[63:0] >= BYTE_SIZE));

   // Multiple ready registers indicate a decode bug; responses are simply ORed.
   always_comb begin
      any_ready      = 1'b0;
      any_error      = 1'b0;
      collected_data = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         if (i_register_ready[i]) begin
            any_ready      = 1'b1;
            any_error      = any_error |
               ((i_register_status[2*i+:2] & RGGEN_STATUS_ERROR) != RGGEN_STATUS_OKAY);
            collected_data = collected_data | i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
         end
      end
   end

   // Response registers are cleared outside the one-cycle response window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state                 <= STATE_IDLE;
         o_register_valid      <= 1'b0;
         o_register_access     <= '0;
         o_register_address    <= '0;
         o_register_write_data <= '0;
         o_register_strobe     <= '0;
         o_response_valid      <= 1'b0;
         o_response_error      <= 1'b0;
         o_response_data       <= '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               o_response_valid <= 1'b0;
               o_response_error <= 1'b0;
               o_response_data  <= '0;
               if (i_request_valid) begin
                  o_register_access     <= i_request_access;
                  o_register_address    <= LOCAL_ADDRESS_WIDTH'(i_request_address) & ADDRESS_MASK;
                  o_register_write_data <= i_request_write_data;
                  o_register_strobe     <= i_request_strobe;
                  if (reject) begin
                     state            <= STATE_RESPONSE;
                     o_response_valid <= 1'b1;
                     o_response_error <= ERROR_STATUS;
                     o_response_data  <= DEFAULT_READ_DATA;
                  end else begin
                     state            <= STATE_ACCESS;
                     o_register_valid <= 1'b1;
                  end
               end
            end
            STATE_ACCESS: begin
               if (any_ready) begin
                  state            <= STATE_RESPONSE;
                  o_register_valid <= 1'b0;
                  o_response_valid <= 1'b1;
                  o_response_error <= any_error;
                  o_response_data  <= o_register_access[RGGEN_ACCESS_WRITE_BIT] ? '0 : collected_data;
               end else if (i_register_active == '0) begin
                  state            <= STATE_RESPONSE;
                  o_register_valid <= 1'b0;
                  o_response_valid <= 1'b1;
                  o_response_error <= ERROR_STATUS;
                  o_response_data  <= DEFAULT_READ_DATA;
               end
            end
            STATE_RESPONSE: begin
               state            <= STATE_IDLE;
               o_response_valid <= 1'b0;
               o_response_error <= 1'b0;
               o_response_data  <= '0;
            end
            default: begin
               state            <= STATE_IDLE;
               o_register_valid <= 1'b0;
               o_response_valid <= 1'b0;
               o_response_error <= 1'b0;
               o_response_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rggen_apb_adapter.sv
// APB4 slave front end: turns APB setup phases into register-bus requests
// through rggen_adapter_common and returns its response as pready/prdata/pslverr.
module rggen_apb_adapter
   import rggen_apb_adapter_pkg::*;
#(
   parameter int              ADDRESS_WIDTH       = 8,
   parameter int              LOCAL_ADDRESS_WIDTH = 8,
   parameter int              BUS_WIDTH           = 32,
   parameter int              REGISTERS           = 1,
   parameter bit              PRE_DECODE          = 1'b0,
   parameter bit [63:0]       BASE_ADDRESS        = '0,
   parameter bit [63:0]       BYTE_SIZE           = 64'd256,
   parameter bit              ERROR_STATUS        = 1'b0,
   parameter bit [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic                           i_pwrite,
   input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
   input  logic [2:0]                     i_pprot,
   input  logic [BUS_WIDTH-1:0]           i_pwdata,
   input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
   output logic                           o_pready,
   output logic [BUS_WIDTH-1:0]           o_prdata,
   output logic                           o_pslverr,
   output logic                           o_register_valid,
   output logic [1:0]                     o_register_access,
   output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
   output logic [BUS_WIDTH-1:0]           o_register_write_data,
   output logic [BUS_WIDTH-1:0]           o_register_strobe,
   input  logic [REGISTERS-1:0]           i_register_active,
   input  logic [REGISTERS-1:0]           i_register_ready,
   input  logic [2*REGISTERS-1:0]         i_register_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

   logic                 request_valid;
   logic [1:0]           request_access;
   logic [BUS_WIDTH-1:0] request_strobe;
   logic                 unused_pprot;

   assign request_valid = i_psel && !i_penable;
   assign unused_pprot  = ^i_pprot[2:1];

   // Reads always see the full word; writes expand pstrb into a bit mask.
   always_comb begin
      request_access                              = '0;
      request_access[RGGEN_ACCESS_WRITE_BIT]      = i_pwrite;
      request_access[RGGEN_ACCESS_PRIVILEGED_BIT] = i_pprot[0];
      request_strobe                              = '1;
      if (i_pwrite) begin
         for (int i = 0; i < BUS_WIDTH / 8; i++) begin
            request_strobe[8*i+:8] = {8{i_pstrb[i]}};
         end
      end
   end

   rggen_adapter_common #(
      .ADDRESS_WIDTH       (ADDRESS_WIDTH),
      .LOCAL_ADDRESS_WIDTH (LOCAL_ADDRESS_WIDTH),
      .BUS_WIDTH           (BUS_WIDTH),
      .REGISTERS           (REGISTERS),
      .PRE_DECODE          (PRE_DECODE),
      .BASE_ADDRESS        (BASE_ADDRESS),
      .BYTE_SIZE           (BYTE_SIZE),
      .ERROR_STATUS        (ERROR_STATUS),
      .DEFAULT_READ_DATA   (DEFAULT_READ_DATA)
   ) u_common (
      .i_clk                 (i_clk),
      .i_rst_n               (i_rst_n),
      .i_request_valid       (request_valid),
      .i_request_access      (request_access),
      .i_request_address     (i_paddr),
      .i_request_write_data  (i_pwdata),
      .i_request_strobe      (request_strobe),
      .o_response_valid      (o_pready),
      .o_response_error      (o_pslverr),
      .o_response_data       (o_prdata),
      .o_register_valid      (o_register_valid),
      .o_register_access     (o_register_access),
      .o_register_address    (o_register_address),
      .o_register_write_data (o_register_write_data),
      .o_register_strobe     (o_register_strobe),
      .i_register_active     (i_register_active),
      .i_register_ready      (i_register_ready),
      .i_register_status     (i_register_status),
      .i_register_read_data  (i_register_read_data)
   );

endmodule

// File: tb/tb_rggen_apb_adapter.sv
// Self-checking bench for rggen_apb_adapter: directed vector table, a reset
// sequence and randomized transfers judged by a transaction-level model.
module tb_rggen_apb_adapter;

   localparam int BUS_WIDTH = 32;

   typedef struct {
      logic        write;
      logic [11:0] addr;
      logic [2:0]  prot;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  hit;
      int          wait_cycles;
      logic [31:0] rdata0;
      logic [31:0] rdata1;
      logic [1:0]  err;
      int          exp_pready_cycle;
      logic        exp_pslverr;
      logic [31:0] exp_prdata;
      int          exp_valid_cycles;
      logic [1:0]  exp_access;
      logic [31:0] exp_strobe;
      logic [7:0]  exp_address;
   } vector_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_psel, i_penable, i_pwrite;
   logic [11:0] i_paddr;
   logic [2:0]  i_pprot;
   logic [31:0] i_pwdata;
   logic [3:0]  i_pstrb;
   logic        o_pready, o_pslverr, o_register_valid;
   logic [31:0] o_prdata, o_register_write_data, o_register_strobe;
   logic [1:0]  o_register_access;
   logic [7:0]  o_register_address;
   logic [1:0]  i_register_active, i_register_ready;
   logic [3:0]  i_register_status;
   logic [63:0] i_register_read_data;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   rggen_apb_adapter #(
      .ADDRESS_WIDTH       (12),
      .LOCAL_ADDRESS_WIDTH (8),
      .BUS_WIDTH           (BUS_WIDTH),
      .REGISTERS           (2),
      .PRE_DECODE          (1'b1),
      .BASE_ADDRESS        (64'h100),
      .BYTE_SIZE           (64'd256),
      .ERROR_STATUS        (1'b1),
      .DEFAULT_READ_DATA   (32'hDEAD_BEEF)
   ) dut (
      .i_clk                 (i_clk),
      .i_rst_n               (i_rst_n),
      .i_psel                (i_psel),
      .i_penable             (i_penable),
      .i_pwrite              (i_pwrite),
      .i_paddr               (i_paddr),
      .i_pprot               (i_pprot),
      .i_pwdata              (i_pwdata),
      .i_pstrb               (i_pstrb),
      .o_pready              (o_pready),
      .o_prdata              (o_prdata),
      .o_pslverr             (o_pslverr),
      .o_register_valid      (o_register_valid),
      .o_register_access     (o_register_access),
      .o_register_address    (o_register_address),
      .o_register_write_data (o_register_write_data),
      .o_register_strobe     (o_register_strobe),
      .i_register_active     (i_register_active),
      .i_register_ready      (i_register_ready),
      .i_register_status     (i_register_status),
      .i_register_read_data  (i_register_read_data)
   );

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Transaction-level expectation: map window, claim, wait states and OR of responders.
   function automatic vector_t model(input vector_t v);
      vector_t r;
      bit      in_map;
      r = v;
      in_map = (v.addr >= 12'h100) && (v.addr < 12'h200);
      r.exp_access  = {v.prot[0], v.write};
      r.exp_address = v.addr[7:0] & 8'hFC;
      for (int b = 0; b < 4; b++)
         r.exp_strobe[8*b+:8] = (v.write && !v.strb[b]) ? 8'h00 : 8'hFF;
      if (!in_map) begin
         r.exp_pready_cycle = 1; r.exp_valid_cycles = 0;
         r.exp_pslverr = 1'b1;   r.exp_prdata = 32'hDEAD_BEEF;
      end else if (v.hit == 2'b00) begin
         r.exp_pready_cycle = 2; r.exp_valid_cycles = 1;
         r.exp_pslverr = 1'b1;   r.exp_prdata = 32'hDEAD_BEEF;
      end else begin
         r.exp_pready_cycle = v.wait_cycles + 2;
         r.exp_valid_cycles = v.wait_cycles + 1;
         r.exp_pslverr = |(v.err & v.hit);
         r.exp_prdata  = v.write ? 32'h0 :
            ((v.hit[0] ? v.rdata0 : 32'h0) | (v.hit[1] ? v.rdata1 : 32'h0));
      end
      return r;
   endfunction

   task automatic clear_register_side();
      i_register_active    = '0;
      i_register_ready     = '0;
      i_register_status    = '0;
      i_register_read_data = '0;
   endtask

   // Called at a negedge; drives one APB transfer, plays the register side, checks it.
   task automatic apply_stimulus(input vector_t v);
      int   n;
      int   pready_cycle;
      int   valid_cycles;
      bit   hold_ok;
      bit   stable_ok;
      logic [7:0] first_addr;
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = v.write; i_paddr = v.addr;
      i_pprot = v.prot; i_pwdata = v.wdata; i_pstrb = v.strb;
      pready_cycle = -1; valid_cycles = 0; hold_ok = 1'b1; stable_ok = 1'b1; first_addr = '0;
      n = 0;
      while (pready_cycle < 0 && n < 64) begin
         @(negedge i_clk);
         n++;
         if (n == 1) i_penable = 1'b1;
         if (o_register_valid) begin
            valid_cycles++;
            if (valid_cycles == 1) begin
               first_addr = o_register_address;
               check_output("req_address", o_register_address, v.exp_address);
               check_output("req_access", o_register_access, v.exp_access);
               check_output("req_strobe", o_register_strobe, v.exp_strobe);
               check_output("req_wdata", o_register_write_data, v.wdata);
            end else if (o_register_address !== first_addr || o_register_access !== v.exp_access ||
                         o_register_strobe !== v.exp_strobe || o_register_write_data !== v.wdata) begin
               stable_ok = 1'b0;
            end
         end
         if (o_pready) begin
            pready_cycle = n;
            check_output("pslverr", o_pslverr, v.exp_pslverr);
            check_output("prdata", o_prdata, v.exp_prdata);
         end else if (o_prdata !== 32'h0 || o_pslverr !== 1'b0) begin
            hold_ok = 1'b0;
         end
         if (o_register_valid && !o_pready) begin
            i_register_active    = v.hit;
            i_register_ready     = (n - 1 == v.wait_cycles) ? v.hit : 2'b00;
            i_register_status    = {v.err[1], 1'b0, v.err[0], 1'b0};
            i_register_read_data = {v.rdata1, v.rdata0};
         end else begin
            clear_register_side();
         end
      end
      check_output("pready_cycle", 64'(pready_cycle), 64'(v.exp_pready_cycle));
      check_output("valid_cycles", 64'(valid_cycles), 64'(v.exp_valid_cycles));
      check_output("resp_hold_zero", hold_ok, 1'b1);
      check_output("req_stable", stable_ok, 1'b1);
      i_psel = 1'b0; i_penable = 1'b0;
      clear_register_side();
      @(negedge i_clk);
      check_output("idle_after", {o_pready, o_pslverr, o_prdata, o_register_valid}, 35'h0);
   endtask

   vector_t table_vec[11];
   vector_t v;

   initial begin
      table_vec[0]  = '{1'b1, 12'h104, 3'b000, 32'h1234_5678, 4'b0011, 2'b01, 0, 32'h0, 32'h0, 2'b00,
                        2, 1'b0, 32'h0, 1, 2'b01, 32'h0000_FFFF, 8'h04};
      table_vec[1]  = '{1'b0, 12'h108, 3'b000, 32'h0, 4'b0000, 2'b10, 3, 32'h1111_1111, 32'hCAFE_F00D, 2'b00,
                        5, 1'b0, 32'hCAFE_F00D, 4, 2'b00, 32'hFFFF_FFFF, 8'h08};
      table_vec[2]  = '{1'b0, 12'h110, 3'b000, 32'h0, 4'b0000, 2'b00, 0, 32'h5, 32'h6, 2'b00,
                        2, 1'b1, 32'hDEAD_BEEF, 1, 2'b00, 32'hFFFF_FFFF, 8'h10};
      table_vec[3]  = '{1'b0, 12'h040, 3'b000, 32'h0, 4'b0000, 2'b01, 0, 32'h0, 32'h0, 2'b00,
                        1, 1'b1, 32'hDEAD_BEEF, 0, 2'b00, 32'hFFFF_FFFF, 8'h40};
      table_vec[4]  = '{1'b0, 12'h10C, 3'b000, 32'h0, 4'b0000, 2'b01, 1, 32'h0000_55AA, 32'h0, 2'b01,
                        3, 1'b1, 32'h0000_55AA, 2, 2'b00, 32'hFFFF_FFFF, 8'h0C};
      table_vec[5]  = '{1'b0, 12'h120, 3'b000, 32'h0, 4'b0000, 2'b11, 0, 32'hF0F0_0000, 32'h0000_0F0F, 2'b10,
                        2, 1'b1, 32'hF0F0_0F0F, 1, 2'b00, 32'hFFFF_FFFF, 8'h20};
      table_vec[6]  = '{1'b1, 12'h1FC, 3'b001, 32'hAABB_CCDD, 4'b1000, 2'b00, 0, 32'h0, 32'h0, 2'b00,
                        2, 1'b1, 32'hDEAD_BEEF, 1, 2'b11, 32'hFF00_0000, 8'hFC};
      table_vec[7]  = '{1'b1, 12'h200, 3'b000, 32'h1, 4'b1111, 2'b01, 0, 32'h0, 32'h0, 2'b00,
                        1, 1'b1, 32'hDEAD_BEEF, 0, 2'b01, 32'hFFFF_FFFF, 8'h00};
      table_vec[8]  = '{1'b0, 12'h0FF, 3'b000, 32'h0, 4'b0000, 2'b01, 0, 32'h0, 32'h0, 2'b00,
                        1, 1'b1, 32'hDEAD_BEEF, 0, 2'b00, 32'hFFFF_FFFF, 8'hFC};
      table_vec[9]  = '{1'b0, 12'h1FF, 3'b000, 32'h0, 4'b0000, 2'b01, 0, 32'h1, 32'h0, 2'b00,
                        2, 1'b0, 32'h1, 1, 2'b00, 32'hFFFF_FFFF, 8'hFC};
      table_vec[10] = '{1'b1, 12'h100, 3'b000, 32'hFFFF_0000, 4'b1111, 2'b10, 2, 32'h0, 32'h1234_5678, 2'b00,
                        4, 1'b0, 32'h0, 3, 2'b01, 32'hFFFF_FFFF, 8'h00};

      i_rst_n = 1'b1;
      i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = '0;
      i_pprot = '0; i_pwdata = '0; i_pstrb = '0;
      clear_register_side();
      #2 i_rst_n = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      check_output("reset_pready", o_pready, 1'b0);
      check_output("reset_pslverr", o_pslverr, 1'b0);
      check_output("reset_prdata", o_prdata, 32'h0);
      check_output("reset_valid", o_register_valid, 1'b0);
      check_output("reset_request", {o_register_access, o_register_address, o_register_write_data, o_register_strobe}, 74'h0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      $display("[TB] directed vector table");
      for (int i = 0; i < 11; i++) apply_stimulus(table_vec[i]);

      $display("[TB] reset during ACCESS");
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1; i_paddr = 12'h130;
      i_pprot = 3'b001; i_pwdata = 32'h5555_AAAA; i_pstrb = 4'b1111;
      @(negedge i_clk);
      i_penable = 1'b1;
      i_register_active = 2'b01;
      check_output("midrst_valid_before", o_register_valid, 1'b1);
      #2 i_rst_n = 1'b0;
      #1;
      check_output("midrst_valid_async", o_register_valid, 1'b0);
      check_output("midrst_outputs", {o_pready, o_pslverr, o_prdata, o_register_access,
                   o_register_address, o_register_write_data, o_register_strobe}, 108'h0);
      i_psel = 1'b0; i_penable = 1'b0;
      clear_register_side();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      v = '{1'b1, 12'h134, 3'b001, 32'h0BAD_C0DE, 4'b0110, 2'b01, 0, 32'h0, 32'h0, 2'b00,
            2, 1'b0, 32'h0, 1, 2'b11, 32'h00FF_FF00, 8'h34};
      apply_stimulus(v);

      $display("[TB] randomized transfers");
      for (int t = 0; t < 40; t++) begin
         v.write       = 1'($urandom_range(0, 1));
         v.addr        = 12'($urandom_range(12'h0C0, 12'h23F));
         v.prot        = 3'($urandom_range(0, 7));
         v.wdata       = $urandom;
         v.strb        = 4'($urandom_range(0, 15));
         v.hit         = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         v.wait_cycles = int'($urandom_range(0, 4));
         v.rdata0      = $urandom;
         v.rdata1      = $urandom;
         v.err         = 2'($urandom_range(0, 3));
         apply_stimulus(model(v));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
